// File: rtl/common_pkg.sv
// Shared types and CLINT register offsets for the data-side memory responder.
// Included by data_memory and clint_regs.
package common;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   localparam logic [15:0] MSIP_OFS     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
   localparam logic [15:0] MTIME_OFS    = 16'hBFF8;

   // Byte span of the CLINT window starting at MMIO_BASE.
   localparam logic [32:0] MMIO_SPAN = 33'h0_0001_0000;

endpackage

// File: rtl/clint_regs.sv
// CLINT-style register block: msip, free-running 64-bit mtime and mtimecmp.
// Only instantiated when DMEM_MMIO_EN is defined.
module clint_regs
   import common::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] offset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        msip,
   output logic        mtip
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;

   // mtime advances every cycle; mtip is a registered compare against mtimecmp.
   always_ff @(posedge clock) begin
      if (reset) begin
         msip     <= 1'b0;
         mtip     <= 1'b0;
         mtime    <= '0;
         mtimecmp <= '1;
      end else begin
         mtime <= mtime + 64'd1;
         mtip  <= (mtime >= mtimecmp);
         if (wr_en) begin
            case (offset)
               MSIP_OFS:              msip            <= wr_data[0];
               MTIMECMP_OFS:          mtimecmp[31:0]  <= wr_data;
               MTIMECMP_OFS + 16'd4:  mtimecmp[63:32] <= wr_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (offset)
         MSIP_OFS:             rd_data = {31'b0, msip};
         MTIMECMP_OFS:         rd_data = mtimecmp[31:0];
         MTIMECMP_OFS + 16'd4: rd_data = mtimecmp[63:32];
         MTIME_OFS:            rd_data = mtime[31:0];
         MTIME_OFS + 16'd4:    rd_data = mtime[63:32];
         default:              rd_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Load/store target: word SRAM with byte lanes, programmable wait states, one-cycle response.
// Define DMEM_MMIO_EN to compile in the CLINT window (msip/mtip sources).
module data_memory
   import common::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] MMIO_BASE   = 32'h0200_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   input  logic [1:0]  write_wstrb,
   output logic [31:0] read_data,
   output logic        mem_valid,
   output logic        access_fault,
   output logic        msip,
   output logic        mtip
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ARR_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [31:0] mem [DEPTH_WORDS];

   dmem_state_t state;
   logic [3:0]  wait_cnt;
   logic [31:0] cap_addr, cap_data;
   mem_size_t   cap_size;
   logic        cap_re, cap_we;

   logic [31:0] acc_addr, acc_data;
   mem_size_t   acc_size;
   logic        acc_re, acc_we;

   logic [32:0] arr_ofs;
   logic [AW-1:0] idx;
   logic        in_arr, in_mmio, mmio_bad, fault, commit;
   logic [4:0]  lane_sh;
   logic [3:0]  bmask;
   logic [31:0] wdata_sh, rword, rshift, rdata_ext, mmio_rdata;
   logic [15:0] mmio_ofs;
   logic        mmio_wr;

   // With no wait states the commit edge is the acceptance edge, so the live
   // inputs are used directly; afterwards the captured copy is authoritative.
   always_comb begin
      if (state == IDLE) begin
         acc_addr = address;
         acc_data = write_data;
         acc_size = mem_size_t'(write_wstrb);
         acc_re   = read_enable;
         acc_we   = write_enable;
      end else begin
         acc_addr = cap_addr;
         acc_data = cap_data;
         acc_size = cap_size;
         acc_re   = cap_re;
         acc_we   = cap_we;
      end
   end

   assign commit = (state == IDLE && (read_enable || write_enable) && NO_WAIT)
                || (state == WAIT && wait_cnt == 4'd0);

   assign arr_ofs = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
   assign in_arr  = !arr_ofs[32] && (arr_ofs < ARR_BYTES);
   assign idx     = AW'(arr_ofs >> 2);

   always_comb begin
      fault = 1'b0;
      case (acc_size)
         SIZE_HALF: fault = acc_addr[0];
         SIZE_WORD: fault = |acc_addr[1:0];
         SIZE_RSVD: fault = 1'b1;
         default:   fault = 1'b0;
      endcase
      if (acc_re && acc_we)
         fault = 1'b1;
      if (!in_arr && !in_mmio)
         fault = 1'b1;
      if (!in_arr && in_mmio && mmio_bad)
         fault = 1'b1;
   end

   assign lane_sh  = {acc_addr[1:0], 3'b000};
   assign wdata_sh = acc_data << lane_sh;

   always_comb begin
      case (acc_size)
         SIZE_BYTE: bmask = 4'b0001 << acc_addr[1:0];
         SIZE_HALF: bmask = 4'b0011 << acc_addr[1:0];
         default:   bmask = 4'b1111;
      endcase
   end

   assign rword  = in_arr ? mem[idx] : mmio_rdata;
   assign rshift = rword >> lane_sh;

   always_comb begin
      case (acc_size)
         SIZE_BYTE: rdata_ext = {24'b0, rshift[7:0]};
         SIZE_HALF: rdata_ext = {16'b0, rshift[15:0]};
         default:   rdata_ext = rshift;
      endcase
   end

   // Array storage is deliberately not reset; reset on the commit edge suppresses the write.
   always_ff @(posedge clock) begin
      if (commit && !reset && acc_we && !fault && in_arr) begin
         for (int b = 0; b < 4; b++) begin
            if (bmask[b])
               mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign mmio_wr = commit && !reset && acc_we && !fault && !in_arr;

`ifdef DMEM_MMIO_EN
   logic [32:0] mmio_ofs33;

   assign mmio_ofs33 = {1'b0, acc_addr} - {1'b0, MMIO_BASE};
   assign in_mmio    = !mmio_ofs33[32] && (mmio_ofs33 < MMIO_SPAN);
   assign mmio_ofs   = mmio_ofs33[15:0];
   assign mmio_bad   = (acc_size != SIZE_WORD)
                    || (acc_we && (mmio_ofs == MTIME_OFS || mmio_ofs == MTIME_OFS + 16'd4));

   clint_regs u_clint (
      .clock   (clock),
      .reset   (reset),
      .offset  (mmio_ofs),
      .wr_en   (mmio_wr),
      .wr_data (acc_data),
      .rd_data (mmio_rdata),
      .msip    (msip),
      .mtip    (mtip)
   );
`else
   logic unused_mmio;

   assign in_mmio     = 1'b0;
   assign mmio_bad    = 1'b0;
   assign mmio_ofs    = '0;
   assign mmio_rdata  = '0;
   assign msip        = 1'b0;
   assign mtip        = 1'b0;
   assign unused_mmio = ^{MMIO_BASE, mmio_wr, mmio_ofs};
`endif

   // Request/wait/response sequencing; response outputs are registered on the commit edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         read_data    <= '0;
         mem_valid    <= 1'b0;
         access_fault <= 1'b0;
         cap_addr     <= '0;
         cap_data     <= '0;
         cap_size     <= SIZE_BYTE;
         cap_re       <= 1'b0;
         cap_we       <= 1'b0;
      end else begin
         mem_valid    <= 1'b0;
         access_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (read_enable || write_enable) begin
                  cap_addr <= address;
                  cap_data <= write_data;
                  cap_size <= mem_size_t'(write_wstrb);
                  cap_re   <= read_enable;
                  cap_we   <= write_enable;
                  if (NO_WAIT) begin
                     state <= RESP;
                  end else begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0)
                  state <= RESP;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (commit) begin
            mem_valid    <= 1'b1;
            access_fault <= fault;
            read_data    <= (fault || acc_we) ? '0 : rdata_ext;
         end
      end
   end

endmodule
